// File: rtl/pb_debounce_capture_if.sv
// Pushbutton conditioning bus: raw pins and clear strobes in, debounced level,
// event pulses and sticky press flags out.
interface pb_debounce_capture_if #(
  parameter int NUM_BTN = 4
) ();
  logic [NUM_BTN-1:0] pb_n_in;
  logic [NUM_BTN-1:0] edge_clr;
  logic [NUM_BTN-1:0] db_n_out;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] long_pulse;
  logic [NUM_BTN-1:0] edge_cap;

  // Board / software side: drives the pins and clear strobes, observes results.
  modport master (
    output pb_n_in,
    output edge_clr,
    input  db_n_out,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  edge_cap
  );

  // Conditioning block side.
  modport slave (
    input  pb_n_in,
    input  edge_clr,
    output db_n_out,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output edge_cap
  );
endinterface

// File: rtl/pb_debounce_capture.sv
// Per-channel pushbutton conditioner for the Nios II button PIO: two-flop
// synchronizer, counter debouncer, press/release pulses, long-press detect and
// a sticky press-capture flag cleared by a software strobe. The debounced bus
// keeps the active-low pin polarity (0 = pressed).
// The interface instance must be built with the same NUM_BTN as this module.
module pb_debounce_capture #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 20,
  parameter int LCNT_W          = 26
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  pb_debounce_capture_if.slave        bus
);

  // Terminal counts: a level is accepted on the DEBOUNCE_CYCLES-th differing
  // sample, a long press fires on the LONG_CYCLES-th held cycle.
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

  logic [NUM_BTN-1:0]             sync1_q, sync2_q;
  logic [NUM_BTN-1:0]             db_q, db_d;
  logic [NUM_BTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_BTN-1:0]             press_q, press_d;
  logic [NUM_BTN-1:0]             release_q, release_d;
  logic [NUM_BTN-1:0][LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [NUM_BTN-1:0]             long_done_q, long_done_d;
  logic [NUM_BTN-1:0]             long_q, long_d;
  logic [NUM_BTN-1:0]             cap_q, cap_d;

  // Two-flop synchronizer; idles at released (all 1s) so a held button is re-qualified after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= {NUM_BTN{1'b1}};
      sync2_q <= {NUM_BTN{1'b1}};
    end else begin
      sync1_q <= bus.pb_n_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state for debouncer, pulses, long-press tracking and press capture.
  always_comb begin
    db_d        = db_q;
    cnt_d       = cnt_q;
    press_d     = {NUM_BTN{1'b0}};
    release_d   = {NUM_BTN{1'b0}};
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    long_d      = {NUM_BTN{1'b0}};
    // A press pulse this cycle wins over a simultaneous clear.
    cap_d       = press_q | (cap_q & ~bus.edge_clr);

    for (int i = 0; i < NUM_BTN; i++) begin
      // Debounce: any sample matching the accepted level restarts qualification.
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == DEB_LAST) begin
        db_d[i]      = sync2_q[i];
        cnt_d[i]     = {CNT_W{1'b0}};
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      // Long press: count held cycles, fire once, then hold until release.
      if (db_q[i]) begin
        lcnt_d[i]      = {LCNT_W{1'b0}};
        long_done_d[i] = 1'b0;
      end else if (!long_done_q[i]) begin
        if (lcnt_q[i] == LONG_LAST) begin
          long_d[i]      = 1'b1;
          long_done_d[i] = 1'b1;
        end else begin
          lcnt_d[i] = lcnt_q[i] + LCNT_ONE;
        end
      end else begin
        lcnt_d[i] = lcnt_q[i];
      end
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      db_q        <= {NUM_BTN{1'b1}};
      cnt_q       <= {(NUM_BTN*CNT_W){1'b0}};
      press_q     <= {NUM_BTN{1'b0}};
      release_q   <= {NUM_BTN{1'b0}};
      lcnt_q      <= {(NUM_BTN*LCNT_W){1'b0}};
      long_done_q <= {NUM_BTN{1'b0}};
      long_q      <= {NUM_BTN{1'b0}};
      cap_q       <= {NUM_BTN{1'b0}};
    end else begin
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
      cap_q       <= cap_d;
    end
  end

  assign bus.db_n_out      = db_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.edge_cap      = cap_q;

endmodule

// File: doc/pb_debounce_capture.md
Name: pb_debounce_capture

Overview:
- Conditions the four raw BeMicro pushbuttons (active-low, bouncing, asynchronous) before they reach the Nios II button PIO input port.
- Per channel: two-flop synchronizer, counter-based debouncer, press/release edge pulses, long-press detection and a sticky press-capture register cleared by software strobe.
- The debounced bus keeps the raw active-low polarity, so it drops directly into the PIO in-port.

Parameters:
- NUM_BTN, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a new level (20 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- LONG_CYCLES, 50000000, cycles of continuous debounced press before long_pulse fires (1 s at 50 MHz); legal range 1 to 2^LCNT_W-1.
- CNT_W, 20, debounce counter width.
- LCNT_W, 26, long-press counter width.

Ports:
- clk_clk  in  1  system clock (SYS_CLK, 50 MHz); all state is on its rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- pb_n_in  in  NUM_BTN  raw pushbutton pins; 0 = pressed.
- edge_clr  in  NUM_BTN  per-bit clear strobe for edge_cap.
- db_n_out  out  NUM_BTN  debounced level; 0 = pressed.
- press_pulse  out  NUM_BTN  one-cycle pulse on a debounced 1->0 transition.
- release_pulse  out  NUM_BTN  one-cycle pulse on a debounced 0->1 transition.
- long_pulse  out  NUM_BTN  one-cycle pulse when a press reaches LONG_CYCLES.
- edge_cap  out  NUM_BTN  sticky flag: a press occurred since the last clear.

Behaviour:
- Reset, asynchronous:
  - Synchronizer flops = all 1s; db_n_out = all 1s (released).
  - press_pulse, release_pulse, long_pulse and edge_cap = 0.
  - All counters = 0; long_done flags = 0.
- Synchronizer: two flops per bit. Call the second flop's output s[i]; it lags pb_n_in by 2 cycles.
- Debounce, per channel, state (db[i], cnt[i]):
  - If s[i] == db[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s; cnt <= 0; fire the transition pulse in the same edge.
  - Else: cnt <= cnt+1.
  - A single glitch sample equal to db resets cnt. A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  - Latency from a clean pin edge to db_n_out change = 2 + DEBOUNCE_CYCLES cycles.
- Pulses: press_pulse and release_pulse are registered and high for exactly the one cycle in which db_n_out first shows the new value. They are never both high on one channel.
- Long press, per channel: lcnt and long_done.
  - While db==0 and long_done==0: lcnt increments.
  - When lcnt == LONG_CYCLES-1: long_pulse = 1 for one cycle; long_done <= 1; lcnt holds.
  - No repeat while the button stays held.
  - When db==1: lcnt <= 0 and long_done <= 0.
  - The release_pulse cycle clears them, so a re-press restarts from 0.
- edge_cap[i]:
  - Set on the press_pulse[i] cycle, i.e. visible the cycle after the pulse.
  - Cleared the cycle after edge_clr[i]==1.
  - If set and clear occur in the same cycle, set wins.
  - edge_clr is level-sensitive; holding it high keeps the bit clear except when a press occurs.
- Channels are fully independent; simultaneous events on different channels need no arbitration.
- Reset mid-debounce or mid-hold discards all progress. After reset a held button is re-qualified from the released state: a press_pulse fires after 2+DEBOUNCE_CYCLES cycles.
- Counters never wrap: the debounce counter is bounded by the compare, and lcnt holds once long_done is set.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=32):
- Reset released, pb_n_in=4'hF for 50 cycles -> db_n_out=4'hF; all pulses and edge_cap stay 0.
- Clean press of pb_n_in[0] (1->0) at cycle T -> db_n_out[0]=0 and press_pulse[0]=1 at exactly T+10 for one cycle; edge_cap=4'b0001 from T+11.
- Bounce on channel 1: toggle every 3 cycles for 30 cycles, then hold 0 -> no pulses during bouncing; one press_pulse[1] 10 cycles after the final stable edge. A 5-cycle pulse-low on channel 2 -> no change.
- Hold channel 3 pressed for 100 cycles -> exactly one long_pulse[3], 32 cycles after its press_pulse. Release -> release_pulse[3] after 10 cycles. Re-press and hold 40 cycles -> a second long_pulse.
- edge_clr[0] asserted in the same cycle as press_pulse[0] -> edge_cap[0] ends 1. edge_clr[0] alone a cycle later -> edge_cap[0]=0 the next cycle.
- Assert reset_reset_n=0 mid-debounce (cnt=5) with the pin held low -> outputs return to reset values immediately. After release, press_pulse fires after a full 10 cycles.
